// File: rtl/ddr_keys_pkg.sv
// Shared scan-code constants, receiver state encoding and key-flag decode
// for the DDR keyboard input stage.
package ddr_keys_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_C     = 8'h21;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

   typedef struct packed {
      logic chg_color;
      logic left;
      logic down;
      logic up;
      logic right;
   } key_flags_t;

   // One-hot game flags for a held key; unmapped keys give all zeros.
   function automatic key_flags_t decode_key(input logic ext, input logic [7:0] code);
      key_flags_t f;
      f = '0;
      if (!ext && code == SC_C) begin
         f.chg_color = 1'b1;
      end
      if (ext) begin
         case (code)
            SC_LEFT:  f.left  = 1'b1;
            SC_DOWN:  f.down  = 1'b1;
            SC_UP:    f.up    = 1'b1;
            SC_RIGHT: f.right = 1'b1;
            default:  f = '0;
         endcase
      end
      return f;
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronisers, ps2_clk glitch filter, 11-bit
// frame FSM with odd-parity/stop check and a mid-frame inactivity timeout.
module ps2_rx_frame
   import ddr_keys_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]            clk_sync_q;
   logic [1:0]            dat_sync_q;
   logic [FILTER_LEN-1:0] filt_sr_q;
   logic                  filt_q, filt_d;
   logic                  fall_q;
   rx_state_e             state_q, state_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [7:0]            shift_q, shift_d;
   logic                  par_q, par_d;
   logic [CNT_W-1:0]      to_cnt_q, to_cnt_d;
   logic                  frame_err_q, frame_err_d;
   logic                  data_bit;

   assign data_bit  = dat_sync_q[1];
   assign rx_byte   = shift_q;
   assign frame_err = frame_err_q;

   always_comb begin
      filt_d = filt_q;
      if (&filt_sr_q) begin
         filt_d = 1'b1;
      end else if (~|filt_sr_q) begin
         filt_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= 2'b11;
         dat_sync_q  <= 2'b11;
         filt_sr_q   <= '1;
         filt_q      <= 1'b1;
         fall_q      <= 1'b0;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         dat_sync_q  <= {dat_sync_q[0], ps2_data};
         filt_sr_q   <= {filt_sr_q[FILTER_LEN-2:0], clk_sync_q[1]};
         filt_q      <= filt_d;
         fall_q      <= filt_q & ~filt_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         to_cnt_q    <= to_cnt_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_d       = par_q;
      to_cnt_d    = '0;
      frame_err_d = 1'b0;
      byte_valid  = 1'b0;

      // A fall on the terminal count keeps the frame alive: fall wins.
      if (state_q != IDLE && !fall_q) begin
         if (to_cnt_q == TO_LAST) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
         end
      end

      if (fall_q) begin
         case (state_q)
            IDLE: begin
               if (!data_bit) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d   = {data_bit, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               par_d   = data_bit;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (data_bit && (^{shift_q, par_q})) begin
                  byte_valid = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// DDR keyboard front end: turns validated PS/2 bytes into a one-shot key
// strobe and held-key flags, tracking E0/F0 prefixes and suppressing repeats.
module ps2_key_decoder
   import ddr_keys_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       keyPressed,
   output logic       btnCHGCOLOR,
   output logic       btnLEFT,
   output logic       btnDOWN,
   output logic       btnUP,
   output logic       btnRIGHT,
   output logic [7:0] scan_code,
   output logic       frame_err
);

   logic       byte_valid;
   logic [7:0] rx_byte;
   logic       rx_err;

   logic       ext_q, ext_d;
   logic       brk_q, brk_d;
   logic       held_ext_q, held_ext_d;
   logic [7:0] held_code_q, held_code_d;
   logic       kp_q, kp_d;
   key_flags_t flags_q, flags_d;
   logic [7:0] scan_q, scan_d;
   logic       held_match;

   ps2_rx_frame #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .frame_err  (rx_err)
   );

   assign held_match = ({ext_q, rx_byte} == {held_ext_q, held_code_q});

   always_comb begin
      ext_d       = ext_q;
      brk_d       = brk_q;
      held_ext_d  = held_ext_q;
      held_code_d = held_code_q;
      kp_d        = 1'b0;
      flags_d     = flags_q;
      scan_d      = scan_q;

      if (rx_err) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end

      if (byte_valid) begin
         if (rx_byte == SC_EXT) begin
            ext_d = 1'b1;
         end else if (rx_byte == SC_BRK) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (!brk_q) begin
               // A make matching the held key is typematic repeat.
               if (!held_match) begin
                  kp_d        = 1'b1;
                  held_ext_d  = ext_q;
                  held_code_d = rx_byte;
                  scan_d      = rx_byte;
                  flags_d     = decode_key(ext_q, rx_byte);
               end
            end else if (held_match) begin
               held_ext_d  = 1'b0;
               held_code_d = 8'h00;
               flags_d     = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         held_ext_q  <= 1'b0;
         held_code_q <= 8'h00;
         kp_q        <= 1'b0;
         flags_q     <= '0;
         scan_q      <= 8'h00;
      end else begin
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         held_ext_q  <= held_ext_d;
         held_code_q <= held_code_d;
         kp_q        <= kp_d;
         flags_q     <= flags_d;
         scan_q      <= scan_d;
      end
   end

   assign keyPressed  = kp_q;
   assign btnCHGCOLOR = flags_q.chg_color;
   assign btnLEFT     = flags_q.left;
   assign btnDOWN     = flags_q.down;
   assign btnUP       = flags_q.up;
   assign btnRIGHT    = flags_q.right;
   assign scan_code   = scan_q;
   assign frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: bit-level PS/2 frames in, a
// byte-stream key model predicts strobe, flags and scan code.
module tb_ps2_key_decoder;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 1500;
   localparam int HALF       = 15;
   localparam int GAP        = 30;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       keyPressed;
   logic       btnCHGCOLOR, btnLEFT, btnDOWN, btnUP, btnRIGHT;
   logic [7:0] scan_code;
   logic       frame_err;

   ps2_key_decoder #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .keyPressed  (keyPressed),
      .btnCHGCOLOR (btnCHGCOLOR),
      .btnLEFT     (btnLEFT),
      .btnDOWN     (btnDOWN),
      .btnUP       (btnUP),
      .btnRIGHT    (btnRIGHT),
      .scan_code   (scan_code),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Pulse monitor, sampled on the falling edge.
   int         cyc = 0;
   int         kp_cnt = 0, fe_cnt = 0, kp_wide = 0, fe_wide = 0, fe_time = 0;
   logic       kp_prev = 1'b0, fe_prev = 1'b0;
   logic [4:0] kp_btn_snap = '0;
   logic [7:0] kp_scan_snap = '0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (keyPressed === 1'b1) begin
         kp_cnt       = kp_cnt + 1;
         kp_btn_snap  = {btnCHGCOLOR, btnLEFT, btnDOWN, btnUP, btnRIGHT};
         kp_scan_snap = scan_code;
         if (kp_prev) kp_wide = kp_wide + 1;
      end
      if (frame_err === 1'b1) begin
         fe_cnt  = fe_cnt + 1;
         fe_time = cyc;
         if (fe_prev) fe_wide = fe_wide + 1;
      end
      kp_prev = (keyPressed === 1'b1);
      fe_prev = (frame_err === 1'b1);
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
      $fatal(1, "watchdog");
   end

   // Byte-stream reference model of the key decoder.
   logic       m_ext = 1'b0, m_brk = 1'b0, m_hext = 1'b0;
   logic [7:0] m_hcode = 8'h00, m_scan = 8'h00;
   logic [4:0] m_btn = 5'b0;
   int         last_fall_cyc = 0;

   function automatic logic [4:0] exp_flags(input logic e, input logic [7:0] c);
      return {(!e && c == 8'h21), (e && c == 8'h6B), (e && c == 8'h72),
              (e && c == 8'h75), (e && c == 8'h74)};
   endfunction

   task automatic model_byte(input logic [7:0] b, output logic pulse);
      logic same;
      pulse = 1'b0;
      same  = (m_ext == m_hext) && (b == m_hcode);
      if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         if (!m_brk && !same) begin
            pulse   = 1'b1;
            m_hext  = m_ext;
            m_hcode = b;
            m_scan  = b;
            m_btn   = exp_flags(m_ext, b);
         end else if (m_brk && same) begin
            m_hext  = 1'b0;
            m_hcode = 8'h00;
            m_btn   = 5'b0;
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic model_error();
      m_ext = 1'b0;
      m_brk = 1'b0;
   endtask

   task automatic model_reset();
      m_ext = 1'b0; m_brk = 1'b0; m_hext = 1'b0;
      m_hcode = 8'h00; m_scan = 8'h00; m_btn = 5'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ps2_fall(input logic d);
      ps2_data = d;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_raw(input logic [7:0] b, input logic par_flip, input int nfalls, input int gap);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < nfalls; i++) ps2_fall(bits[i]);
      ps2_data = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, " scan_code"}, 32'(scan_code), 32'(m_scan));
      check({tag, " btn"}, 32'({btnCHGCOLOR, btnLEFT, btnDOWN, btnUP, btnRIGHT}), 32'(m_btn));
      check({tag, " pulse_width"}, 32'(kp_wide + fe_wide), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad);
      int   kp0, fe0;
      logic exp_kp;
      string tag;
      kp0 = kp_cnt;
      fe0 = fe_cnt;
      exp_kp = 1'b0;
      if (bad) model_error();
      else model_byte(b, exp_kp);
      send_raw(b, bad, 11, GAP);
      tag = $sformatf("byte %02h%s", b, bad ? " badpar" : "");
      check({tag, " keyPressed_count"}, 32'(kp_cnt - kp0), 32'(exp_kp));
      check({tag, " frame_err_count"}, 32'(fe_cnt - fe0), 32'(bad));
      if (exp_kp) begin
         check({tag, " btn_at_pulse"}, 32'(kp_btn_snap), 32'(m_btn));
         check({tag, " scan_at_pulse"}, 32'(kp_scan_snap), 32'(m_scan));
      end
      check_outputs(tag);
      $display("txn byte=%02h bad=%0d kp=%0d btn=%05b scan=%02h", b, bad, exp_kp, m_btn, m_scan);
   endtask

   task automatic key_make(input logic e, input logic [7:0] c);
      if (e) send_byte(8'hE0, 1'b0);
      send_byte(c, 1'b0);
   endtask

   task automatic key_break(input logic e, input logic [7:0] c);
      if (e) send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(c, 1'b0);
   endtask

   initial begin
      int         kp0, fe0, lat, sel, act;
      logic       e;
      logic [7:0] c;
      logic [7:0] arrows [4];
      arrows[0] = 8'h6B; arrows[1] = 8'h72; arrows[2] = 8'h75; arrows[3] = 8'h74;

      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      check("reset keyPressed", 32'(keyPressed), 32'd0);
      check("reset frame_err", 32'(frame_err), 32'd0);
      check_outputs("reset");
      rst = 1'b0;
      repeat (GAP) @(negedge clk);

      // C key: make, typematic repeat, break.
      key_make(1'b0, 8'h21);
      key_make(1'b0, 8'h21);
      key_break(1'b0, 8'h21);

      // Arrow keys.
      for (int i = 0; i < 4; i++) begin
         key_make(1'b1, arrows[i]);
         key_break(1'b1, arrows[i]);
      end

      // Parity error then good 0x1C.
      send_byte(8'h1C, 1'b1);
      send_byte(8'h1C, 1'b0);

      // Timeout mid-frame after E0; prefix must be dropped.
      send_byte(8'hE0, 1'b0);
      kp0 = kp_cnt; fe0 = fe_cnt;
      send_raw(8'h55, 1'b0, 5, 0);
      for (int i = 0; i < 3 * TIMEOUT && fe_cnt == fe0; i++) @(negedge clk);
      repeat (GAP) @(negedge clk);
      model_error();
      lat = fe_time - last_fall_cyc;
      check("timeout frame_err_count", 32'(fe_cnt - fe0), 32'd1);
      check("timeout latency_in_range", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 30), 32'd1);
      check("timeout keyPressed_count", 32'(kp_cnt - kp0), 32'd0);
      check_outputs("timeout");
      $display("txn timeout latency=%0d", lat);
      send_byte(8'h6B, 1'b0);
      send_byte(8'h21, 1'b0);

      // Short ps2_clk glitch in IDLE with data low.
      kp0 = kp_cnt; fe0 = fe_cnt;
      ps2_data = 1'b0; ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (GAP) @(negedge clk);
      check("glitch pulses", 32'((kp_cnt - kp0) + (fe_cnt - fe0)), 32'd0);
      $display("txn glitch");
      key_make(1'b1, 8'h75);

      // Reset in the middle of a frame.
      kp0 = kp_cnt; fe0 = fe_cnt;
      send_raw(8'h21, 1'b0, 5, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      model_reset();
      check("midrst keyPressed", 32'(keyPressed), 32'd0);
      check_outputs("midrst");
      rst = 1'b0;
      repeat (GAP) @(negedge clk);
      check("midrst pulses", 32'((kp_cnt - kp0) + (fe_cnt - fe0)), 32'd0);
      $display("txn midframe_reset");
      send_byte(8'h21, 1'b0);

      // Randomised key traffic.
      for (int it = 0; it < 30; it++) begin
         sel = int'($urandom_range(0, 6));
         act = int'($urandom_range(0, 9));
         e = 1'b0;
         c = 8'h21;
         if (sel >= 1 && sel <= 4) begin
            e = 1'b1;
            c = arrows[sel-1];
         end else if (sel == 5) begin
            c = 8'h1C;
         end else if (sel == 6) begin
            e = 1'($urandom_range(0, 1));
            c = 8'($urandom_range(1, 223));
         end
         if (act < 5) key_make(e, c);
         else if (act < 6) key_make(m_hext, m_hcode);
         else if (act < 8) key_break(m_hext, m_hcode);
         else if (act < 9) key_break(e, c);
         else send_byte(8'($urandom_range(0, 255)), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
